// File: rtl/sp1_arith_arb.sv
// Round-robin arbiter sharing one add/incr/decr datapath among four requesters.
// One winner per cycle; result and one-hot ack are registered.
module sp1_arith_arb #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [7:0]      op,
    input  logic [4*DW-1:0] a,
    input  logic [4*DW-1:0] b,
    output logic [3:0]      ack,
    output logic [DW-1:0]   y,
    output logic            c
);

    logic [1:0]    ptr;
    logic [3:0]    elig;
    logic [7:0]    elig2;
    logic [3:0]    rot;
    logic [1:0]    off;
    logic [1:0]    w;
    logic          any;

    logic [1:0]    sel_op;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [DW-1:0] opnd;
    logic          is_decr;
    logic [DW:0]   sum;

    // A requester sitting in its ack cycle must not be re-issued.
    assign elig  = req & ~ack;
    assign elig2 = {elig, elig};
    assign rot   = elig2[ptr +: 4];
    assign any   = |elig;

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            rot[3]:  off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    assign w = ptr + off;

    assign sel_op = op[{w, 1'b0} +: 2];
    assign sel_a  = a[w*DW +: DW];
    assign sel_b  = b[w*DW +: DW];

    // Decrement adds all-ones; borrow is the inverted carry.
    always_comb begin
        opnd    = sel_b;
        is_decr = 1'b0;
        case (sel_op)
            2'b01: opnd = {{(DW-1){1'b0}}, 1'b1};
            2'b10: begin
                opnd    = '1;
                is_decr = 1'b1;
            end
            default: opnd = sel_b;
        endcase
    end

    assign sum = {1'b0, sel_a} + {1'b0, opnd};

    always_ff @(posedge clk) begin
        if (rst) begin
            ack <= 4'b0000;
            y   <= '0;
            c   <= 1'b0;
            ptr <= 2'd0;
        end else if (any) begin
            ack <= 4'b0001 << w;
            y   <= sum[DW-1:0];
            c   <= sum[DW] ^ is_decr;
            ptr <= w + 2'd1;
        end else begin
            ack <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_sp1_arith_arb.sv
// Directed self-checking bench for sp1_arith_arb.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_sp1_arith_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [7:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   ack;
    logic [31:0]  y;
    logic         c;

    int checks;
    int failures;

    sp1_arith_arb #(.DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .op  (op),
        .a   (a),
        .b   (b),
        .ack (ack),
        .y   (y),
        .c   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [1:0] o,
                            input logic [31:0] av, input logic [31:0] bv);
        op[2*i +: 2] = o;
        a[32*i +: 32] = av;
        b[32*i +: 32] = bv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One lone request, dropped in its ack cycle, then one idle cycle.
    task automatic issue_one(input int i, input logic [1:0] o,
                             input logic [31:0] av, input logic [31:0] bv,
                             output logic [3:0] ack_o,
                             output logic [31:0] y_o,
                             output logic c_o);
        set_lane(i, o, av, bv);
        req = 4'b0001 << i;
        tick();
        ack_o = ack;
        y_o   = y;
        c_o   = c;
        req   = 4'b0000;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        op  = '0;
        a   = '0;
        b   = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack got=%b exp=0000", ack);
        end
        checks++;
        if (y !== 32'h0) begin
            failures++;
            $display("FAIL reset_y got=%h exp=00000000", y);
        end
        checks++;
        if (c !== 1'b0) begin
            failures++;
            $display("FAIL reset_c got=%b exp=0", c);
        end
        tick();
        checks++;
        if (ack !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ack got=%b exp=0000", ack);
        end
    endtask

    task automatic test_basic_add();
        do_reset();
        set_lane(0, 2'b00, 32'h5, 32'h3);
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || y !== 32'h8 || c !== 1'b0) begin
            failures++;
            $display("FAIL add_first got ack=%b y=%h c=%b exp ack=0001 y=00000008 c=0",
                     ack, y, c);
        end
        tick();
        checks++;
        if (ack !== 4'b0000 || y !== 32'h8) begin
            failures++;
            $display("FAIL add_ackgap got ack=%b y=%h exp ack=0000 y=00000008", ack, y);
        end
        set_lane(0, 2'b00, 32'h10, 32'h20);
        tick();
        checks++;
        if (ack !== 4'b0001 || y !== 32'h30) begin
            failures++;
            $display("FAIL add_reissue got ack=%b y=%h exp ack=0001 y=00000030", ack, y);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000 || y !== 32'h30) begin
            failures++;
            $display("FAIL add_done got ack=%b y=%h exp ack=0000 y=00000030", ack, y);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ack [5];
        logic [31:0] exp_y   [5];
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_y   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 2'b01, 32'(i), 32'hDEAD_0000);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (ack !== exp_ack[k] || y !== exp_y[k] || c !== 1'b0) begin
                failures++;
                $display("FAIL rr_step%0d got ack=%b y=%h c=%b exp ack=%b y=%h c=0",
                         k, ack, y, c, exp_ack[k], exp_y[k]);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap_borrow();
        logic [3:0]  ack_o;
        logic [31:0] y_o;
        logic        c_o;
        logic [1:0]  vop [5];
        logic [31:0] va  [5];
        logic [31:0] vb  [5];
        logic [31:0] ey  [5];
        logic        ec  [5];
        vop = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
        va  = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1, 32'h1234_5678};
        vb  = '{32'h0, 32'h0, 32'h8000_0000, 32'h0, 32'h0};
        ey  = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1234_5679};
        ec  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue_one(k % 4, vop[k], va[k], vb[k], ack_o, y_o, c_o);
            checks++;
            if (ack_o !== (4'b0001 << (k % 4)) || y_o !== ey[k] || c_o !== ec[k]) begin
                failures++;
                $display("FAIL wrap%0d got ack=%b y=%h c=%b exp y=%h c=%b",
                         k, ack_o, y_o, c_o, ey[k], ec[k]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  ack_o;
        logic [31:0] y_o;
        logic        c_o;
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 2'b01, 32'(10 * i), 32'h0);
        issue_one(2, 2'b01, 32'd20, 32'd0, ack_o, y_o, c_o);
        checks++;
        if (ack_o !== 4'b0100 || y_o !== 32'd21) begin
            failures++;
            $display("FAIL rot_prime got ack=%b y=%h exp ack=0100 y=00000015", ack_o, y_o);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (ack !== 4'b0001 || y !== 32'd1) begin
            failures++;
            $display("FAIL rot_first got ack=%b y=%h exp ack=0001 y=00000001", ack, y);
        end
        req = 4'b0100;
        tick();
        checks++;
        if (ack !== 4'b0100 || y !== 32'd21) begin
            failures++;
            $display("FAIL rot_second got ack=%b y=%h exp ack=0100 y=00000015", ack, y);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (ack !== 4'b1000 || y !== 32'd31) begin
            failures++;
            $display("FAIL rot_third got ack=%b y=%h exp ack=1000 y=0000001f", ack, y);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || y !== 32'd1) begin
            failures++;
            $display("FAIL rot_fourth got ack=%b y=%h exp ack=0001 y=00000001", ack, y);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [3:0]  ack_o;
        logic [31:0] y_o;
        logic        c_o;
        do_reset();
        issue_one(0, 2'b00, 32'h11, 32'h22, ack_o, y_o, c_o);
        checks++;
        if (ack_o !== 4'b0001 || y_o !== 32'h33) begin
            failures++;
            $display("FAIL mid_prime got ack=%b y=%h exp ack=0001 y=00000033", ack_o, y_o);
        end
        set_lane(1, 2'b00, 32'hFFFF_FFFF, 32'h2);
        req = 4'b0010;
        rst = 1'b1;
        tick();
        checks++;
        if (ack !== 4'b0000 || y !== 32'h0 || c !== 1'b0) begin
            failures++;
            $display("FAIL mid_discard got ack=%b y=%h c=%b exp ack=0000 y=00000000 c=0",
                     ack, y, c);
        end
        rst = 1'b0;
        set_lane(0, 2'b01, 32'h40, 32'h0);
        set_lane(1, 2'b10, 32'h50, 32'h0);
        req = 4'b0011;
        tick();
        checks++;
        if (ack !== 4'b0001 || y !== 32'h41) begin
            failures++;
            $display("FAIL mid_after got ack=%b y=%h exp ack=0001 y=00000041", ack, y);
        end
        req = 4'b0010;
        tick();
        checks++;
        if (ack !== 4'b0010 || y !== 32'h4F || c !== 1'b0) begin
            failures++;
            $display("FAIL mid_next got ack=%b y=%h c=%b exp ack=0010 y=0000004f c=0",
                     ack, y, c);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_op11_isolation();
        logic [3:0]  ack_o;
        logic [31:0] y_o;
        logic        c_o;
        do_reset();
        set_lane(1, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
        set_lane(2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_lane(3, 2'b01, 32'h0BAD_F00D, 32'h1);
        issue_one(0, 2'b11, 32'd7, 32'd9, ack_o, y_o, c_o);
        checks++;
        if (ack_o !== 4'b0001 || y_o !== 32'd16 || c_o !== 1'b0) begin
            failures++;
            $display("FAIL op11 got ack=%b y=%h c=%b exp ack=0001 y=00000010 c=0",
                     ack_o, y_o, c_o);
        end
        for (int k = 0; k < 3; k++) begin
            set_lane(1 + k, 2'(k), 32'h1000 * (k + 1), 32'hFFFF_FFF0);
            tick();
            checks++;
            if (ack !== 4'b0000 || y !== 32'd16 || c !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d got ack=%b y=%h c=%b exp ack=0000 y=00000010 c=0",
                         k, ack, y, c);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        req = 4'b0000;
        op  = '0;
        a   = '0;
        b   = '0;
        test_reset();
        test_basic_add();
        test_round_robin();
        test_wrap_borrow();
        test_rotation();
        test_reset_midflight();
        test_op11_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp1_arith_arb.md
# sp1_arith_arb

Round-robin arbiter and sequencer that shares one DW-bit add/increment/decrement datapath among four requesters. Examples are heap-pointer bump, stack-pointer push/pop and update-frame arithmetic. Each requester presents an opcode and operands under a req/ack handshake. The block selects one winner per cycle, computes the result through a single shared adder, and returns the registered result with a one-hot ack one cycle later.

## Interface
- DW, 32, datapath width of operands and result
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  4  request per requester i; level, held until ack[i]
- op  in  8  opcode of requester i at op[2i+1:2i]: 00 add (a+b), 01 incr (a+1), 10 decr (a-1), 11 treated as add
- a  in  4*DW  operand A of requester i at a[DW*i+DW-1:DW*i]
- b  in  4*DW  operand B of requester i, same packing; ignored for incr/decr
- ack  out  4  one-hot, registered; ack[i]=1 for exactly one cycle when y/c carry requester i's result
- y  out  DW  registered result, low DW bits
- c  out  1  registered carry (add/incr) or borrow (decr)

## Operation
- State: rr pointer ptr[1:0]; ack register; y/c result registers.
- Eligibility: elig[i] = req[i] & ~ack[i]. A requester in its ack cycle is never re-issued in that same cycle.
- Arbitration is combinational over elig, with priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible index is winner w.
- Issue: if any elig, the datapath computes on requester w's op/a/b. At the clock edge:
  - ack <= one-hot(w)
  - {c,y} <= result
  - ptr <= w+1 mod 4
- No issue: ack <= 0; y, c and ptr hold.
- Arithmetic, all DW+1 bit, unsigned:
  - add: {c,y} = a + b
  - incr: {c,y} = a + 1
  - decr: {c,y} = a - 1, so c=1 exactly when a==0
  - op 11 behaves identically to 00.
- Requester rules:
  - op/a/b must be stable from req assertion through the cycle before ack.
  - Deassert req in the ack cycle to finish.
  - Holding req high in the ack cycle with new op/a/b counts as a new request, eligible from the following cycle.
- Reset values: ack=0, y=0, c=0, ptr=0.
- Reset mid-operation: rst high at the edge following issue discards the in-flight result; no ack is produced. Requesters are reset by the same rst and must not expect completion.
- Dropping req before ack is illegal. If it happens, the op may still complete and ack is still pulsed.
- op/a/b of non-winning requesters have no effect.

## Timing
- Latency: req[i] sampled high and winning at edge t gives ack[i], y, c valid in the cycle after t. Minimum one cycle.
- Throughput: one operation per cycle across requesters. One requester alone issues at most every other cycle, because of the ack-cycle ineligibility.
- Fairness: with all four requesting continuously, each is granted exactly once per 4 issues. Worst-case wait from req to issue is 3 issues of other requesters.
- The datapath is a single adder plus operand mux: the B input is b for add and constant 1 or all-ones for incr/decr. Its combinational path ends at the y/c registers, and no output is combinational from inputs.
- Back-to-back acks to different requesters on consecutive cycles are legal; y/c change every cycle in that case.

## Test plan
- Reset, then req=0001, op=00, a0=0x0000_0005, b0=0x0000_0003 -> next cycle ack=0001, y=0x0000_0008, c=0. Hold req 1 more cycle -> no issue that cycle (ack=0000), re-issue after.
- req=1111 from reset (ptr=0), all op=01, a_i=i -> acks 0001, 0010, 0100, 1000 on four consecutive cycles with y=1, 2, 3, 4. Then 0001 repeats if req is still held.
- Wrap and borrow:
  - incr a=0xFFFF_FFFF -> y=0x0000_0000, c=1
  - decr a=0x0000_0000 -> y=0xFFFF_FFFF, c=1
  - add 0x8000_0000+0x8000_0000 -> y=0, c=1
  - decr a=1 -> y=0, c=0
- Rotation: after an ack to requester 2, assert req=0101 -> requester 0 wins only after ptr=3 finds no request at index 3. Expected ack=0001 then 0100; ptr=1 after the first issue.
- Reset mid-flight: issue requester 1, assert rst at the next edge -> ack stays 0000, y=0, c=0, ptr=0. After rst drops, req=0011 -> ack=0001 first.
- Op 11 with a=7, b=9 -> y=16, c=0. Other requesters' changing operands while not granted do not alter y.
